// File: rtl/uart_receiver_if.sv
// Serial-receive bundle: the RX line in, recovered byte, strobes and status out.
interface uart_receiver_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;

    modport slave  (input rx,  output data, output valid, output busy, output frame_err);
    modport master (output rx, input data,  input valid,  input busy,  input frame_err);
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes the RX line, centres on each bit and recovers bytes
// with a one-cycle valid strobe or a one-cycle framing-error strobe.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int CNT_W        = 11
) (
    input  logic            i_clk,
    input  logic            i_rst,
    uart_receiver_if.slave  rx_if
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        WAIT  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             rx_p0;
    logic             rx_p1;

    assign rx_if.busy = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rx_p0           <= 1'b1;
            rx_p1           <= 1'b1;
            state           <= IDLE;
            cnt             <= '0;
            bit_idx         <= '0;
            shift           <= '0;
            rx_if.data      <= '0;
            rx_if.valid     <= 1'b0;
            rx_if.frame_err <= 1'b0;
        end else begin
            // stage p0/p1: two-flop synchronizer; only rx_p1 drives decisions
            rx_p0           <= rx_if.rx;
            rx_p1           <= rx_p0;
            rx_if.valid     <= 1'b0;
            rx_if.frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_p1) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    // Re-check at mid start bit so short low glitches are rejected
                    if (cnt == HALF_LAST) begin
                        if (rx_p1) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            cnt     <= '0;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == FULL_LAST) begin
                        shift[bit_idx] <= rx_p1;
                        cnt            <= '0;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit leaves half a bit to catch a back-to-back start
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (rx_p1) begin
                            rx_if.data  <= shift;
                            rx_if.valid <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            rx_if.frame_err <= 1'b1;
                            state           <= WAIT;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (rx_p1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit: vector table plus
// hand-written sequences for back-to-back, glitch, mid-frame reset and ASCII sweep.
module tb_uart_receiver;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    uart_receiver_if bus();

    uart_receiver #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .rx_if (bus)
    );

    always #5 clk = ~clk;

    // Passive monitor: records every valid pulse and every protocol violation
    logic [7:0] got_q[$];
    int         got_t[$];
    int         cyc       = 0;
    int         ferr_cnt  = 0;
    int         overlap   = 0;
    int         wide      = 0;
    logic       prev_v    = 1'b0;
    logic       prev_f    = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.valid) begin
            got_q.push_back(bus.data);
            got_t.push_back(cyc);
        end
        if (bus.frame_err) ferr_cnt = ferr_cnt + 1;
        if (bus.valid && bus.frame_err) overlap = overlap + 1;
        if ((bus.valid && prev_v) || (bus.frame_err && prev_f)) wide = wide + 1;
        prev_v = bus.valid;
        prev_f = bus.frame_err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        bus.rx = 1'b0;
        clocks(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            clocks(CPB);
        end
        bus.rx = stop_bit;
        clocks(CPB);
    endtask

    typedef struct {
        logic [7:0] tx_byte;
        logic       stop_bit;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base_n;
        int base_f;

        vecs[0] = '{8'h55, 1'b1, 1, 0, 8'h55};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[3] = '{8'hA3, 1'b0, 0, 1, 8'hFF};
        vecs[4] = '{8'h81, 1'b1, 1, 0, 8'h81};
        vecs[5] = '{8'hA3, 1'b1, 1, 0, 8'hA3};

        bus.rx = 1'b1;
        rst    = 1'b0;
        clocks(5);
        check("rst_data",  32'(bus.data),      32'h00);
        check("rst_valid", 32'(bus.valid),     32'h0);
        check("rst_busy",  32'(bus.busy),      32'h0);
        check("rst_ferr",  32'(bus.frame_err), 32'h0);
        rst = 1'b1;
        clocks(CPB);

        for (int v = 0; v < 6; v++) begin
            base_n = got_q.size();
            base_f = ferr_cnt;
            send_frame(vecs[v].tx_byte, vecs[v].stop_bit);
            if (!vecs[v].stop_bit) begin
                clocks(3 * CPB - 2);
                check($sformatf("v%0d_busy_held", v), 32'(bus.busy), 32'h1);
                clocks(2);
                bus.rx = 1'b1;
            end
            clocks(3 * CPB);
            check($sformatf("v%0d_nvalid", v), 32'(got_q.size() - base_n), 32'(vecs[v].exp_valid));
            check($sformatf("v%0d_nferr", v),  32'(ferr_cnt - base_f),      32'(vecs[v].exp_ferr));
            check($sformatf("v%0d_data", v),   32'(bus.data),               32'(vecs[v].exp_data));
            check($sformatf("v%0d_idle", v),   32'(bus.busy),               32'h0);
        end

        // Back-to-back frames with no idle gap
        base_n = got_q.size();
        send_frame(8'h41, 1'b1);
        send_frame(8'h7E, 1'b1);
        clocks(3 * CPB);
        check("b2b_count", 32'(got_q.size() - base_n), 32'd2);
        if (got_q.size() - base_n == 2) begin
            check("b2b_first",  32'(got_q[base_n]),     32'h41);
            check("b2b_second", 32'(got_q[base_n + 1]), 32'h7E);
            check("b2b_gap",    32'(got_t[base_n + 1] - got_t[base_n]), 32'd160);
        end

        // Short low glitch on an idle line
        base_n = got_q.size();
        base_f = ferr_cnt;
        bus.rx = 1'b0;
        clocks(4);
        bus.rx = 1'b1;
        clocks(2);
        check("glitch_busy", 32'(bus.busy), 32'h1);
        clocks(2 * CPB);
        check("glitch_idle",  32'(bus.busy), 32'h0);
        check("glitch_valid", 32'(got_q.size() - base_n), 32'd0);
        check("glitch_ferr",  32'(ferr_cnt - base_f),     32'd0);

        // Reset during bit 4 of 0xFF, then a clean 0x20
        base_n = got_q.size();
        base_f = ferr_cnt;
        bus.rx = 1'b0;
        clocks(CPB);
        bus.rx = 1'b1;
        clocks(4 * CPB + CPB / 2);
        rst = 1'b0;
        clocks(3);
        check("midrst_data",  32'(bus.data),      32'h00);
        check("midrst_busy",  32'(bus.busy),      32'h0);
        check("midrst_valid", 32'(bus.valid),     32'h0);
        check("midrst_ferr",  32'(bus.frame_err), 32'h0);
        rst = 1'b1;
        clocks(6 * CPB);
        check("midrst_nopulse", 32'(got_q.size() - base_n), 32'd0);
        check("midrst_noferr",  32'(ferr_cnt - base_f),     32'd0);
        send_frame(8'h20, 1'b1);
        clocks(2 * CPB);
        check("after_rst_count", 32'(got_q.size() - base_n), 32'd1);
        check("after_rst_data",  32'(bus.data),              32'h20);

        // ASCII sweep, frames sent back to back
        base_n = got_q.size();
        base_f = ferr_cnt;
        for (int c = 8'h20; c <= 8'h7E; c++) send_frame(8'(c), 1'b1);
        clocks(3 * CPB);
        check("sweep_count", 32'(got_q.size() - base_n), 32'd95);
        check("sweep_ferr",  32'(ferr_cnt - base_f),     32'd0);
        if (got_q.size() - base_n == 95) begin
            for (int c = 0; c < 95; c++)
                check($sformatf("sweep_%0h", c + 32), 32'(got_q[base_n + c]), 32'(c + 32));
        end

        check("pulse_overlap", 32'(overlap), 32'd0);
        check("pulse_width",   32'(wide),    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
